// File: rtl/bus_device_port_pkg.sv
// bus_port_pkg
// Shared constants, types and helpers for the bus_device_port endpoint.
//   ADDR_W        width of the destination address carried in a packet
//   BCAST_DEFAULT broadcast destination that every device accepts
//   PKT_MAX_W     widest packet dest_of() can take apart
//   drop_cnt_t    saturating dropped-packet counter type
//   dest_of()     returns the ADDR_W bits ending at bit 'msb' of a packet
package bus_port_pkg;

  localparam int unsigned ADDR_W        = 8;
  localparam logic [ADDR_W-1:0] BCAST_DEFAULT = 8'hFF;
  localparam int unsigned PKT_MAX_W     = 64;

  typedef logic [7:0] drop_cnt_t;

  // Packets narrower than PKT_MAX_W are zero-extended by the caller, so
  // the destination is addressed by its top bit rather than by the width.
  function automatic logic [ADDR_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input logic [5:0]           msb);
    return pkt[msb -: ADDR_W];
  endfunction

endpackage

// File: rtl/bus_device_port_if.sv
// bus_device_port_if
// Bus-side signals between the bs_gnrtr_n_rbtr driver and one endpoint.
//   pndng   endpoint has a packet for the bus
//   pop     bus takes the TX head
//   D_pop   TX head word (first-word fall-through)
//   push    bus delivers a packet
//   D_push  delivered packet
// master = bus driver side, slave = endpoint side.
interface bus_device_port_if #(parameter int unsigned width = 16);

  logic             pndng;
  logic             pop;
  logic [width-1:0] D_pop;
  logic             push;
  logic [width-1:0] D_push;

  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);

endinterface

// File: rtl/bus_device_port_fifo.sv
// sync_fwft_fifo
// Single-clock circular-buffer FIFO with the head word shown directly from
// the storage array (first-word fall-through).
//   clk, reset  clock, synchronous active-high reset (clears storage too,
//               so the head reads 0 after reset)
//   wr, wdata   write request and data; ignored when full unless a read
//               happens in the same cycle
//   rd          read request; advances the head on the next edge
//   rdata       current head word
//   empty/full  occupancy flags, derived from the registered count
//   underflow   single-cycle pulse when rd is asserted while empty
module sync_fwft_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [width-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign rdata     = mem[rd_ptr];
  assign underflow = rd && empty;

  // A read only frees a slot when there is something to read, so an empty
  // FIFO never passes a same-cycle write straight through.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

endmodule

// File: rtl/bus_device_port.sv
// bus_device_port
// Per-slot endpoint for the bs_gnrtr_n_rbtr bus driver.
//   clk, reset     clock, synchronous active-high reset
//   bus            bus-side interface (slave): pndng/pop/D_pop for TX,
//                  push/D_push for RX
//   tx_wr/tx_data  host writes into the TX FIFO; tx_full when no room
//   rx_rd/rx_data  host drains the RX FIFO (FWFT); rx_valid, rx_full
//   err_ovf        sticky: accepted packet dropped because RX was full
//   err_misroute   sticky: packet addressed to another device
//   err_underflow  sticky: pop or rx_rd while the FIFO was empty
//   drop_cnt       dropped RX packets, saturating at 255
//   clr_err        clears the sticky flags and drop_cnt on the next edge
// width must be 16..64; ID must fit in ADDR_W bits.
module bus_device_port
  import bus_port_pkg::*;
#(
  parameter int unsigned       width = 16,
  parameter int unsigned       DEPTH = 8,
  parameter int unsigned       ID    = 0,
  parameter logic [ADDR_W-1:0] BCAST = BCAST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_device_port_if.slave     bus,
  input  logic                 tx_wr,
  input  logic [width-1:0]     tx_data,
  output logic                 tx_full,
  input  logic                 rx_rd,
  output logic [width-1:0]     rx_data,
  output logic                 rx_valid,
  output logic                 rx_full,
  output logic                 err_ovf,
  output logic                 err_misroute,
  output logic                 err_underflow,
  output drop_cnt_t            drop_cnt,
  input  logic                 clr_err
);

  localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(ID);

  logic              tx_empty;
  logic              tx_uf;
  logic              rx_empty;
  logic              rx_uf;
  logic [ADDR_W-1:0] dest;
  logic              dest_ok;
  logic              rx_wr;
  logic              misroute_evt;
  logic              ovf_evt;
  logic              drop_evt;
  logic              underflow_evt;

  sync_fwft_fifo #(.width(width), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (tx_wr),
    .wdata     (tx_data),
    .rd        (bus.pop),
    .rdata     (bus.D_pop),
    .empty     (tx_empty),
    .full      (tx_full),
    .underflow (tx_uf)
  );

  sync_fwft_fifo #(.width(width), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (rx_wr),
    .wdata     (bus.D_push),
    .rd        (rx_rd),
    .rdata     (rx_data),
    .empty     (rx_empty),
    .full      (rx_full),
    .underflow (rx_uf)
  );

  assign bus.pndng = !tx_empty;
  assign rx_valid  = !rx_empty;

  // A foreign destination is classed as a misroute even if RX is also
  // full, so a packet is only ever counted once.
  assign dest          = dest_of(PKT_MAX_W'(bus.D_push), 6'(width - 1));
  assign dest_ok       = (dest == MY_ADDR) || (dest == BCAST);
  assign rx_wr         = bus.push && dest_ok;
  assign misroute_evt  = bus.push && !dest_ok;
  assign ovf_evt       = rx_wr && rx_full && !rx_rd;
  assign drop_evt      = misroute_evt || ovf_evt;
  assign underflow_evt = tx_uf || rx_uf;

  // A same-cycle error event beats clr_err, so nothing is lost by clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf       <= 1'b0;
      err_misroute  <= 1'b0;
      err_underflow <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      err_ovf       <= ovf_evt       || (err_ovf       && !clr_err);
      err_misroute  <= misroute_evt  || (err_misroute  && !clr_err);
      err_underflow <= underflow_evt || (err_underflow && !clr_err);
      if (clr_err)
        drop_cnt <= drop_evt ? drop_cnt_t'(1) : '0;
      else if (drop_evt && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_device_port.sv
// tb_bus_device_port
// Directed bench for bus_device_port with width=16, DEPTH=4, ID=3.
// Each stimulus step drives inputs, waits for one rising edge, samples 1
// time unit later and then returns all inputs to idle.
module tb_bus_device_port;
  import bus_port_pkg::*;

  logic        clk;
  logic        reset;
  logic        tx_wr;
  logic [15:0] tx_data;
  logic        tx_full;
  logic        rx_rd;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_full;
  logic        err_ovf;
  logic        err_misroute;
  logic        err_underflow;
  drop_cnt_t   drop_cnt;
  logic        clr_err;

  int checkCount = 0;
  int passCount  = 0;

  bus_device_port_if #(.width(16)) bus ();

  bus_device_port #(.width(16), .DEPTH(4), .ID(3), .BCAST(8'hFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .tx_wr         (tx_wr),
    .tx_data       (tx_data),
    .tx_full       (tx_full),
    .rx_rd         (rx_rd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_full       (rx_full),
    .err_ovf       (err_ovf),
    .err_misroute  (err_misroute),
    .err_underflow (err_underflow),
    .drop_cnt      (drop_cnt),
    .clr_err       (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single place where every comparison is counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] wd, input logic p,
                               input logic ps, input logic [15:0] pd, input logic rr,
                               input logic clr, input logic rst);
    tx_wr      = wr;
    tx_data    = wd;
    bus.pop    = p;
    bus.push   = ps;
    bus.D_push = pd;
    rx_rd      = rr;
    clr_err    = clr;
    reset      = rst;
    @(posedge clk);
    #1;
    tx_wr      = 1'b0;
    tx_data    = '0;
    bus.pop    = 1'b0;
    bus.push   = 1'b0;
    bus.D_push = '0;
    rx_rd      = 1'b0;
    clr_err    = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic hostWrite(input logic [15:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic busPop();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic busPush(input logic [15:0] d);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hostRead();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clearErrors();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkErrors(input string tag, input logic ovf, input logic mis,
                             input logic uf, input logic [7:0] cnt);
    checkOutput({tag, "_err_ovf"},       32'(err_ovf),       32'(ovf));
    checkOutput({tag, "_err_misroute"},  32'(err_misroute),  32'(mis));
    checkOutput({tag, "_err_underflow"}, 32'(err_underflow), 32'(uf));
    checkOutput({tag, "_drop_cnt"},      32'(drop_cnt),      32'(cnt));
  endtask

  initial begin
    logic [15:0] wordsA [4];
    logic [15:0] rxExp  [4];

    tx_wr = 0; tx_data = 0; bus.pop = 0; bus.push = 0; bus.D_push = 0;
    rx_rd = 0; clr_err = 0; reset = 1;

    // Reset, with pop and a write held to show they are ignored.
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 16'h0399, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_pndng",    32'(bus.pndng), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid),  32'd0);
    checkOutput("rst_tx_full",  32'(tx_full),   32'd0);
    checkOutput("rst_rx_full",  32'(rx_full),   32'd0);
    checkOutput("rst_D_pop",    32'(bus.D_pop), 32'h0);
    checkOutput("rst_rx_data",  32'(rx_data),   32'h0);
    checkErrors("rst", 1'b0, 1'b0, 1'b0, 8'd0);

    // Two TX words, popped in order.
    hostWrite(16'h0311);
    checkOutput("tx1_pndng", 32'(bus.pndng), 32'd1);
    checkOutput("tx1_D_pop", 32'(bus.D_pop), 32'h0311);
    hostWrite(16'h0322);
    checkOutput("tx2_D_pop", 32'(bus.D_pop), 32'h0311);
    busPop();
    checkOutput("tx_pop1_pndng", 32'(bus.pndng), 32'd1);
    checkOutput("tx_pop1_D_pop", 32'(bus.D_pop), 32'h0322);
    busPop();
    checkOutput("tx_pop2_pndng", 32'(bus.pndng), 32'd0);
    checkOutput("tx_pop2_uf",    32'(err_underflow), 32'd0);

    // Five writes into a 4-deep TX FIFO; the fifth is discarded.
    wordsA = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
    for (int i = 0; i < 4; i++) begin
      hostWrite(wordsA[i]);
      checkOutput($sformatf("txfill%0d_full", i), 32'(tx_full), 32'(i == 3));
    end
    hostWrite(16'h0A05);
    checkOutput("txfill5_full", 32'(tx_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("txdrain%0d_D_pop", i), 32'(bus.D_pop), 32'(wordsA[i]));
      busPop();
    end
    checkOutput("txdrain_pndng", 32'(bus.pndng), 32'd0);
    for (int i = 0; i < 4; i++) begin
      hostWrite(16'h0B00 + 16'(i));
      checkOutput($sformatf("txwrap%0d_D_pop", i), 32'(bus.D_pop), 32'h0B00 + 32'(i));
      busPop();
      checkOutput($sformatf("txwrap%0d_pndng", i), 32'(bus.pndng), 32'd0);
    end

    // RX: own address, broadcast, then a foreign destination.
    busPush(16'h03AA);
    checkOutput("rx1_valid", 32'(rx_valid), 32'd1);
    checkOutput("rx1_data",  32'(rx_data),  32'h03AA);
    busPush(16'hFF55);
    busPush(16'h0577);
    checkErrors("misroute", 1'b0, 1'b1, 1'b0, 8'd1);
    checkOutput("rx_head_after_mis", 32'(rx_data), 32'h03AA);
    hostRead();
    checkOutput("rx2_data", 32'(rx_data), 32'hFF55);
    hostRead();
    checkOutput("rx_drained_valid", 32'(rx_valid), 32'd0);
    clearErrors();
    checkErrors("clr1", 1'b0, 1'b0, 1'b0, 8'd0);

    // RX full: misroute wins over overflow, then a real overflow, then a
    // push accepted because rx_rd frees a slot in the same cycle.
    for (int i = 0; i < 4; i++) busPush(16'h0301 + 16'(i));
    checkOutput("rxfull_full", 32'(rx_full), 32'd1);
    busPush(16'h0499);
    checkErrors("mis_full", 1'b0, 1'b1, 1'b0, 8'd1);
    clearErrors();
    busPush(16'h0305);
    checkErrors("ovf", 1'b1, 1'b0, 1'b0, 8'd1);
    checkOutput("ovf_rx_data", 32'(rx_data), 32'h0301);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h0306, 1'b1, 1'b0, 1'b0);
    checkOutput("wr_rd_full_full", 32'(rx_full), 32'd1);
    checkOutput("wr_rd_full_cnt",  32'(drop_cnt), 32'd1);
    rxExp = '{16'h0302, 16'h0303, 16'h0304, 16'h0306};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rxdrain%0d_data", i), 32'(rx_data), 32'(rxExp[i]));
      hostRead();
    end
    checkOutput("rxdrain_valid", 32'(rx_valid), 32'd0);
    clearErrors();

    // Underflow on each side, leaving both FIFOs empty.
    busPop();
    checkOutput("txuf_flag",  32'(err_underflow), 32'd1);
    checkOutput("txuf_pndng", 32'(bus.pndng),     32'd0);
    clearErrors();
    checkOutput("txuf_clr", 32'(err_underflow), 32'd0);
    hostRead();
    checkOutput("rxuf_flag",  32'(err_underflow), 32'd1);
    checkOutput("rxuf_valid", 32'(rx_valid),      32'd0);

    // Write and pop together on an empty TX FIFO: write kept, pop underflows.
    clearErrors();
    applyStimulus(1'b1, 16'h0C01, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("empty_wrrd_pndng", 32'(bus.pndng),     32'd1);
    checkOutput("empty_wrrd_D_pop", 32'(bus.D_pop),     32'h0C01);
    checkOutput("empty_wrrd_uf",    32'(err_underflow), 32'd1);
    busPop();

    // An error event in the clearing cycle survives the clear.
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h0577, 1'b0, 1'b1, 1'b0);
    checkErrors("clr_evt", 1'b0, 1'b1, 1'b0, 8'd1);
    clearErrors();
    checkErrors("clr2", 1'b0, 1'b0, 1'b0, 8'd0);

    // drop_cnt saturates at 255.
    for (int i = 0; i < 260; i++) busPush(16'h0700);
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);
    clearErrors();

    // Mid-operation reset with pop asserted discards the TX contents.
    hostWrite(16'h0D0A);
    hostWrite(16'h0D0B);
    hostWrite(16'h0D0C);
    applyStimulus(1'b1, 16'h0EEE, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_pndng", 32'(bus.pndng), 32'd0);
    checkOutput("midrst_D_pop", 32'(bus.D_pop), 32'h0);
    hostWrite(16'h0D01);
    checkOutput("postrst_pndng", 32'(bus.pndng), 32'd1);
    checkOutput("postrst_D_pop", 32'(bus.D_pop), 32'h0D01);
    busPop();
    checkOutput("postrst_empty", 32'(bus.pndng), 32'd0);
    checkOutput("postrst_uf",    32'(err_underflow), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
